// File: rtl/ps2_parser_pkg.sv
// Shared constants for the PS/2 Set-2 scancode parser: prefixes, keymap codes, bit indices, FSM states.
package ps2_parser_pkg;

    localparam logic [7:0] PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PREFIX_BRK = 8'hF0;

    // Set-2 make codes; the four arrow keys are only valid behind an E0 prefix
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_P     = 8'h4D;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_C     = 8'h21;
    localparam logic [7:0] SC_N     = 8'h31;
    localparam logic [7:0] SC_Q     = 8'h15;

    localparam logic [3:0] KEY_W     = 4'd0;
    localparam logic [3:0] KEY_A     = 4'd1;
    localparam logic [3:0] KEY_S     = 4'd2;
    localparam logic [3:0] KEY_D     = 4'd3;
    localparam logic [3:0] KEY_UP    = 4'd4;
    localparam logic [3:0] KEY_LEFT  = 4'd5;
    localparam logic [3:0] KEY_DOWN  = 4'd6;
    localparam logic [3:0] KEY_RIGHT = 4'd7;
    localparam logic [3:0] KEY_SPACE = 4'd8;
    localparam logic [3:0] KEY_ENTER = 4'd9;
    localparam logic [3:0] KEY_ESC   = 4'd10;
    localparam logic [3:0] KEY_P     = 4'd11;
    localparam logic [3:0] KEY_R     = 4'd12;
    localparam logic [3:0] KEY_C     = 4'd13;
    localparam logic [3:0] KEY_N     = 4'd14;
    localparam logic [3:0] KEY_Q     = 4'd15;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } ps2_fsm_t;

endpackage

// File: rtl/ps2_parser_keymap.sv
// Combinational scancode lookup: {ext, code} -> {hit, idx}. Extended and plain codes are distinct keys.
module ps2_parser_keymap
    import ps2_parser_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output logic       hit,
    output logic [3:0] idx
);

    always_comb begin
        hit = 1'b1;
        idx = 4'd0;
        case ({ext, code})
            {1'b0, SC_W}:     idx = KEY_W;
            {1'b0, SC_A}:     idx = KEY_A;
            {1'b0, SC_S}:     idx = KEY_S;
            {1'b0, SC_D}:     idx = KEY_D;
            {1'b1, SC_UP}:    idx = KEY_UP;
            {1'b1, SC_LEFT}:  idx = KEY_LEFT;
            {1'b1, SC_DOWN}:  idx = KEY_DOWN;
            {1'b1, SC_RIGHT}: idx = KEY_RIGHT;
            {1'b0, SC_SPACE}: idx = KEY_SPACE;
            {1'b0, SC_ENTER}: idx = KEY_ENTER;
            {1'b0, SC_ESC}:   idx = KEY_ESC;
            {1'b0, SC_P}:     idx = KEY_P;
            {1'b0, SC_R}:     idx = KEY_R;
            {1'b0, SC_C}:     idx = KEY_C;
            {1'b0, SC_N}:     idx = KEY_N;
            {1'b0, SC_Q}:     idx = KEY_Q;
            default:          hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_parser.sv
// PS/2 Set-2 scancode stream -> 16-bit held-key vector, handling E0/F0 prefixes.
// Define PS2_PARSER_TOGGLE_EN to make each key press toggle its bit instead of tracking the held level.
module ps2_parser
    import ps2_parser_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ps2_byte,
    input  logic        ps2_state,
    output logic [15:0] keys
);

    logic       ps2_state_q;
    logic       new_byte;
    ps2_fsm_t   state;
    ps2_fsm_t   state_nxt;
    logic       key_ext;
    logic       key_hit;
    logic [3:0] key_idx;
    logic       do_make;
    logic       do_brk;

    // Cleared at reset so a level already high when reset releases still registers as a byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ps2_state_q <= 1'b0;
        else        ps2_state_q <= ps2_state;
    end

    assign new_byte = ps2_state & ~ps2_state_q;
    assign key_ext  = (state == EXT) || (state == EXT_BRK);

    ps2_parser_keymap u_keymap (
        .ext  (key_ext),
        .code (ps2_byte),
        .hit  (key_hit),
        .idx  (key_idx)
    );

    always_comb begin
        state_nxt = state;
        do_make   = 1'b0;
        do_brk    = 1'b0;
        if (new_byte) begin
            case (state)
                IDLE: begin
                    if (ps2_byte == PREFIX_BRK)      state_nxt = BRK;
                    else if (ps2_byte == PREFIX_EXT) state_nxt = EXT;
                    else                             do_make   = key_hit;
                end
                EXT: begin
                    if (ps2_byte == PREFIX_BRK)      state_nxt = EXT_BRK;
                    else if (ps2_byte != PREFIX_EXT) begin
                        do_make   = key_hit;
                        state_nxt = IDLE;
                    end
                end
                BRK, EXT_BRK: begin
                    do_brk    = key_hit;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

`ifdef PS2_PARSER_TOGGLE_EN
    // A set latch bit means this key's make already toggled; only its break re-arms it
    logic [15:0] make_seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keys      <= 16'h0000;
            make_seen <= 16'h0000;
        end else if (do_make) begin
            if (!make_seen[key_idx]) keys[key_idx] <= ~keys[key_idx];
            make_seen[key_idx] <= 1'b1;
        end else if (do_brk) begin
            make_seen[key_idx] <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       keys          <= 16'h0000;
        else if (do_make) keys[key_idx] <= 1'b1;
        else if (do_brk)  keys[key_idx] <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_ps2_parser.sv
// Self-checking bench for ps2_parser: directed scenarios plus a randomized byte stream against a prefix-flag model.
module tb_ps2_parser;

    logic        clk;
    logic        rst_n;
    logic [7:0]  ps2_byte;
    logic        ps2_state;
    logic [15:0] keys;

    int checks;
    int failures;

    // Reference model: pending-prefix flags plus a code table searched linearly
    logic [8:0]  key_tab [16];
    logic [15:0] m_keys;
    logic [15:0] m_latch;
    bit          m_ext;
    bit          m_brk;

    ps2_parser dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_byte  (ps2_byte),
        .ps2_state (ps2_state),
        .keys      (keys)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: keys=%04h expected=%04h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_keys  = 16'h0000;
        m_latch = 16'h0000;
        m_ext   = 0;
        m_brk   = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int hit_idx;
        hit_idx = -1;
        for (int i = 0; i < 16; i++)
            if (key_tab[i] == {m_ext, b}) hit_idx = i;
        if (m_brk) begin
            if (hit_idx >= 0) begin
`ifdef PS2_PARSER_TOGGLE_EN
                m_latch[hit_idx] = 1'b0;
`else
                m_keys[hit_idx] = 1'b0;
`endif
            end
            m_ext = 0;
            m_brk = 0;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else begin
            if (hit_idx >= 0) begin
`ifdef PS2_PARSER_TOGGLE_EN
                if (!m_latch[hit_idx]) m_keys[hit_idx] = ~m_keys[hit_idx];
                m_latch[hit_idx] = 1'b1;
`else
                m_keys[hit_idx] = 1'b1;
`endif
            end
            m_ext = 0;
        end
    endtask

    task automatic send(input logic [7:0] b, input int hold, input int gap);
        @(negedge clk);
        ps2_byte  = b;
        ps2_state = 1'b1;
        model_byte(b);
        repeat (hold) @(negedge clk);
        ps2_state = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset", keys, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] pool [20];
        checks   = 0;
        failures = 0;
        key_tab = '{9'h01D, 9'h01C, 9'h01B, 9'h023, 9'h175, 9'h16B, 9'h172, 9'h174,
                    9'h029, 9'h05A, 9'h076, 9'h04D, 9'h02D, 9'h021, 9'h031, 9'h015};
        pool = '{8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B,
                 8'h72, 8'h74, 8'h29, 8'h5A, 8'h76, 8'h4D, 8'h2D, 8'h21, 8'h31, 8'h15};
        model_reset();
        rst_n     = 1'b0;
        ps2_byte  = 8'h00;
        ps2_state = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", keys, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Held strobe consumes exactly one byte
        ps2_byte  = 8'h23;
        ps2_state = 1'b1;
        model_byte(8'h23);
        @(negedge clk);
        check("held_first_edge", keys, 16'h0008);
        repeat (19) @(negedge clk);
        check("held_20_cycles", keys, 16'h0008);
        ps2_state = 1'b0;
        @(negedge clk);

`ifndef PS2_PARSER_TOGGLE_EN
        send(8'hF0, 1, 1); send(8'h23, 1, 1);
        check("break_d", keys, 16'h0000);
        send(8'hE0, 2, 1); send(8'h75, 2, 1);
        check("make_up", keys, 16'h0010);
        send(8'h75, 1, 1);
        check("kp8_not_up", keys, 16'h0010);
        send(8'hE0, 1, 1); send(8'hF0, 1, 1); send(8'h75, 1, 1);
        check("break_up", keys, 16'h0000);
        send(8'h1D, 1, 1); send(8'h1C, 1, 1); send(8'h29, 1, 1);
        check("make_w_a_sp", keys, 16'h0103);
        send(8'h1C, 1, 1);
        check("repeat_make", keys, 16'h0103);
        send(8'hF0, 1, 1); send(8'h1C, 1, 1);
        check("break_a", keys, 16'h0101);
        send(8'hF0, 1, 1); send(8'h1C, 1, 1);
        check("break_clear_bit", keys, 16'h0101);
        send(8'h44, 1, 1); send(8'hAA, 1, 1); send(8'hFA, 1, 1); send(8'h00, 1, 1);
        check("unmapped", keys, 16'h0101);
        send(8'hF0, 1, 1); send(8'hE0, 1, 1); send(8'h75, 1, 1);
        check("brk_e0_ignored", keys, 16'h0101);
`else
        send(8'hF0, 1, 1); send(8'h23, 1, 1);
        check("tgl_break", keys, 16'h0008);
        send(8'h23, 1, 1);
        check("tgl_again", keys, 16'h0000);
        send(8'h1D, 1, 1); send(8'h1D, 1, 1);
        check("tgl_repeat", keys, 16'h0001);
`endif

        // Reset discards a pending break prefix
        send(8'hF0, 1, 1);
        do_reset();
        send(8'h23, 1, 1);
        check("reset_mid_seq", keys, 16'h0008);

        // A level already high when reset releases counts as a byte
        @(negedge clk);
        rst_n     = 1'b0;
        model_reset();
        ps2_byte  = 8'h1B;
        ps2_state = 1'b1;
        repeat (2) @(negedge clk);
        check("high_in_reset", keys, 16'h0000);
        rst_n = 1'b1;
        model_byte(8'h1B);
        @(negedge clk);
        check("high_at_release", keys, 16'h0004);
        ps2_state = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 400; n++) begin
            logic [7:0] b;
            if ($urandom_range(0, 7) == 0) b = 8'($urandom);
            else                           b = pool[$urandom_range(0, 19)];
            send(b, $urandom_range(1, 3), $urandom_range(1, 2));
            check("random", keys, m_keys);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
